// File: rtl/counter_pkg.sv
// Shared definitions for the universal modulo counter.
// Holds mode constants and the operation decode used by the top level.
package counter_pkg;

    // Boundary behaviour selected by the SAT parameter
    localparam bit CNT_WRAP = 1'b0;
    localparam bit CNT_SAT  = 1'b1;

    // Operation chosen for one clock edge once priority is resolved.
    // OP_HOLD covers both hdb=0 and en=0.
    typedef enum logic [2:0] {
        OP_CLR  = 3'd0,
        OP_LD   = 3'd1,
        OP_HOLD = 3'd2,
        OP_UP   = 3'd3,
        OP_DN   = 3'd4
    } op_e;

    // Resolve the active-low controls in priority order:
    // clear > load > hold > disable > count (direction from upb).
    function automatic op_e decode_op(
        input logic clrb,
        input logic ldb,
        input logic hdb,
        input logic en,
        input logic upb
    );
        op_e op;
        if (!clrb) begin
            op = OP_CLR;
        end else if (!ldb) begin
            op = OP_LD;
        end else if (!hdb || !en) begin
            op = OP_HOLD;
        end else if (upb) begin
            op = OP_DN;
        end else begin
            op = OP_UP;
        end
        return op;
    endfunction

endpackage

// File: rtl/mod_step_alu.sv
// Combinational modulo step: next value and boundary flag for one count.
// Ports: q (current), s (clamped step), dn (1=down) -> nxt, ovf.
module mod_step_alu
    import counter_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int MODULO = 256,
    parameter bit SAT    = CNT_WRAP
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] s,
    input  logic             dn,
    output logic [WIDTH-1:0] nxt,
    output logic             ovf
);

    // Modulus needs one extra bit when MODULO == 2**WIDTH
    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULO);
    // Truncated modulus: 0 when MODULO == 2**WIDTH, which is still
    // correct for the wrap arithmetic below since it is mod 2**WIDTH.
    localparam logic [WIDTH-1:0] MOD_T = WIDTH'(MODULO);
    localparam logic [WIDTH-1:0] LIMIT = WIDTH'(MODULO - 1);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = {1'b0, q} + {1'b0, s};
        nxt = q;
        ovf = 1'b0;
        if (!dn) begin
            if (sum < MOD_W) begin
                nxt = sum[WIDTH-1:0];
            end else begin
                ovf = 1'b1;
                // Wrapped result is below MODULO, so the WIDTH-bit
                // form of q+s-MODULO is exact.
                nxt = (SAT == CNT_SAT) ? LIMIT : (q + s - MOD_T);
            end
        end else begin
            if (q >= s) begin
                nxt = q - s;
            end else begin
                ovf = 1'b1;
                nxt = (SAT == CNT_SAT) ? '0 : (q + MOD_T - s);
            end
        end
    end

endmodule

// File: rtl/univ_mod_counter.sv
// Universal modulo counter with step, wrap/saturate, cascade and flags.
// Ports: clk, rstb, en, clrb, ldb, hdb, upb, d, step, cmp -> q, tc, ovf, ld_err, match.
module univ_mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int MODULO = 256,
    parameter bit SAT    = CNT_WRAP
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             en,
    input  logic             clrb,
    input  logic             ldb,
    input  logic             hdb,
    input  logic             upb,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] cmp,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf,
    output logic             ld_err,
    output logic             match
);

    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULO);
    localparam logic [WIDTH-1:0] LIMIT = WIDTH'(MODULO - 1);

    op_e             op;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] alu_nxt;
    logic             alu_ovf;
    logic             d_big;

    always_comb begin
        op = decode_op(clrb, ldb, hdb, en, upb);
    end

    // A step larger than the range would skip past a full cycle;
    // clamp it so one edge never moves more than MODULO-1.
    assign s     = (step > LIMIT) ? LIMIT : step;
    assign d_big = ({1'b0, d} >= MOD_W);

    mod_step_alu #(
        .WIDTH  (WIDTH),
        .MODULO (MODULO),
        .SAT    (SAT)
    ) u_alu (
        .q   (q),
        .s   (s),
        .dn  (upb),
        .nxt (alu_nxt),
        .ovf (alu_ovf)
    );

    // Flags default to 0 every edge so they pulse for exactly one cycle
    always_ff @(posedge clk) begin
        if (!rstb) begin
            q      <= '0;
            ovf    <= 1'b0;
            ld_err <= 1'b0;
        end else begin
            ovf    <= 1'b0;
            ld_err <= 1'b0;
            unique case (op)
                OP_CLR: begin
                    q <= '0;
                end
                OP_LD: begin
                    q      <= d_big ? LIMIT : d;
                    ld_err <= d_big;
                end
                OP_HOLD: begin
                    q <= q;
                end
                OP_UP, OP_DN: begin
                    q   <= alu_nxt;
                    ovf <= alu_ovf;
                end
                default: begin
                    q <= q;
                end
            endcase
        end
    end

    assign tc    = upb ? (q == '0) : (q == LIMIT);
    assign match = (q == cmp);

endmodule

// File: tb/tb_univ_mod_counter.sv
// Self-checking bench for univ_mod_counter: vector table, corner
// sequences, randomized run against a reference model, and a cascade.
module tb_univ_mod_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Shared controls for the wrap, saturate and full-range instances
    logic       rstb, en, clrb, ldb, hdb, upb;
    logic [7:0] d, step, cmp;
    logic [3:0] f_d, f_step, f_cmp;

    logic [7:0] w_q, s_q;
    logic [3:0] f_q;
    logic       w_tc, w_ovf, w_le, w_mt;
    logic       s_tc, s_ovf, s_le, s_mt;
    logic       f_tc, f_ovf, f_le, f_mt;

    univ_mod_counter #(.WIDTH(8), .MODULO(10), .SAT(1'b0)) dut_w (
        .clk(clk), .rstb(rstb), .en(en), .clrb(clrb), .ldb(ldb),
        .hdb(hdb), .upb(upb), .d(d), .step(step), .cmp(cmp),
        .q(w_q), .tc(w_tc), .ovf(w_ovf), .ld_err(w_le), .match(w_mt)
    );

    univ_mod_counter #(.WIDTH(8), .MODULO(10), .SAT(1'b1)) dut_s (
        .clk(clk), .rstb(rstb), .en(en), .clrb(clrb), .ldb(ldb),
        .hdb(hdb), .upb(upb), .d(d), .step(step), .cmp(cmp),
        .q(s_q), .tc(s_tc), .ovf(s_ovf), .ld_err(s_le), .match(s_mt)
    );

    univ_mod_counter #(.WIDTH(4), .MODULO(16), .SAT(1'b0)) dut_f (
        .clk(clk), .rstb(rstb), .en(en), .clrb(clrb), .ldb(ldb),
        .hdb(hdb), .upb(upb), .d(f_d), .step(f_step), .cmp(f_cmp),
        .q(f_q), .tc(f_tc), .ovf(f_ovf), .ld_err(f_le), .match(f_mt)
    );

    // Two chained decade stages
    logic       c_rstb, c_one;
    logic [7:0] c_zero, c_step;
    logic [7:0] lo_q, hi_q;
    logic       lo_tc, lo_ovf, lo_le, lo_mt;
    logic       hi_tc, hi_ovf, hi_le, hi_mt;
    logic       hi_en;
    assign hi_en = lo_tc & c_one;

    univ_mod_counter #(.WIDTH(8), .MODULO(10), .SAT(1'b0)) dut_lo (
        .clk(clk), .rstb(c_rstb), .en(c_one), .clrb(c_one), .ldb(c_one),
        .hdb(c_one), .upb(1'b0), .d(c_zero), .step(c_step), .cmp(c_zero),
        .q(lo_q), .tc(lo_tc), .ovf(lo_ovf), .ld_err(lo_le), .match(lo_mt)
    );

    univ_mod_counter #(.WIDTH(8), .MODULO(10), .SAT(1'b0)) dut_hi (
        .clk(clk), .rstb(c_rstb), .en(hi_en), .clrb(c_one), .ldb(c_one),
        .hdb(c_one), .upb(1'b0), .d(c_zero), .step(c_step), .cmp(c_zero),
        .q(hi_q), .tc(hi_tc), .ovf(hi_ovf), .ld_err(hi_le), .match(hi_mt)
    );

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rb, cb, lb, hb, e, u,
                         input int dv, sv, cv);
        rstb = rb; clrb = cb; ldb = lb; hdb = hb; en = e; upb = u;
        d = 8'(dv); step = 8'(sv); cmp = 8'(cv);
    endtask

    // Reference model: plain integer arithmetic on the counting rules
    typedef struct {
        int q;
        bit ovf;
        bit lerr;
    } mst_t;

    function automatic mst_t ref_next(mst_t c, int m, bit sat,
                                      bit rb, cb, lb, hb, e, u,
                                      int dv, int sv);
        mst_t r;
        int   s;
        int   t;
        r.q = c.q;
        r.ovf = 1'b0;
        r.lerr = 1'b0;
        if (!rb || !cb) begin
            r.q = 0;
        end else if (!lb) begin
            if (dv < m) r.q = dv;
            else begin
                r.q = m - 1;
                r.lerr = 1'b1;
            end
        end else if (hb && e) begin
            s = (sv < m - 1) ? sv : m - 1;
            t = u ? c.q - s : c.q + s;
            if (t >= m) begin
                r.ovf = 1'b1;
                r.q = sat ? m - 1 : t - m;
            end else if (t < 0) begin
                r.ovf = 1'b1;
                r.q = sat ? 0 : t + m;
            end else begin
                r.q = t;
            end
        end
        return r;
    endfunction

    typedef struct {
        logic rb, cb, lb, hb, e, u;
        int   dv, sv, cv;
        int   q, ovf, le, tc, mt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rb, cb, lb, hb, e, u,
                                int dv, sv, cv, q, ovf, le, tc, mt);
        vec_t v;
        v.rb = rb; v.cb = cb; v.lb = lb; v.hb = hb; v.e = e; v.u = u;
        v.dv = dv; v.sv = sv; v.cv = cv;
        v.q = q; v.ovf = ovf; v.le = le; v.tc = tc; v.mt = mt;
        return v;
    endfunction

    mst_t mw, ms, mf;

    initial begin
        c_one = 1'b1; c_zero = 8'd0; c_step = 8'd1; c_rstb = 1'b0;
        f_d = '0; f_step = '0; f_cmp = '0;
        drive(0, 1, 1, 1, 1, 0, 0, 3, 5);

        // Wrap instance, MODULO=10
        //             rb cb lb hb e u  d   st  cm   q ovf le tc mt
        tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0,   3,  5,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 1, 0, 0,   3,  5,  3, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 1, 0, 0,   3,  5,  6, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 1, 0, 0,   3,  5,  9, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 1, 1, 1, 0, 0,   3,  5,  2, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 1, 1, 0,   4,  5,  8, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 1, 1, 0,   4,  5,  4, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 1, 1, 0,   4,  5,  0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0, 1, 1, 1, 200, 4,  5,  9, 0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 1, 0, 0,   3,  5,  9, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 1, 1, 0, 0, 0,   3,  5,  9, 0, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 0, 200, 3,  5,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 1, 0, 5,   3,  5,  5, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 1, 1, 0, 0,   0,  5,  5, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 1, 1, 0, 0, 200,  5,  4, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 1, 0, 9,   1,  5,  9, 0, 0, 1, 0));
        tbl.push_back(mk(1, 1, 1, 1, 1, 0, 0,   1,  5,  0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 1, 0, 0,   7,  5,  7, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 1, 0, 0,   3,  5,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1, 1, 0, 0,   0,  0,  0, 0, 0, 0, 1));

        foreach (tbl[i]) begin
            drive(tbl[i].rb, tbl[i].cb, tbl[i].lb, tbl[i].hb, tbl[i].e,
                  tbl[i].u, tbl[i].dv, tbl[i].sv, tbl[i].cv);
            tick();
            check($sformatf("vec%0d q", i), int'(w_q), tbl[i].q);
            check($sformatf("vec%0d ovf", i), int'(w_ovf), tbl[i].ovf);
            check($sformatf("vec%0d ld_err", i), int'(w_le), tbl[i].le);
            check($sformatf("vec%0d tc", i), int'(w_tc), tbl[i].tc);
            check($sformatf("vec%0d match", i), int'(w_mt), tbl[i].mt);
        end

        // Saturating instance at both limits
        drive(0, 1, 1, 1, 1, 0, 0, 0, 0);  tick();
        check("sat reset q", int'(s_q), 0);
        check("sat reset match", int'(s_mt), 1);
        drive(1, 1, 0, 1, 1, 0, 8, 5, 0);  tick();
        check("sat load q", int'(s_q), 8);
        drive(1, 1, 1, 1, 1, 0, 0, 5, 0);  tick();
        check("sat up q", int'(s_q), 9);
        check("sat up ovf", int'(s_ovf), 1);
        check("sat up tc", int'(s_tc), 1);
        tick();
        check("sat hold-at-top q", int'(s_q), 9);
        check("sat hold-at-top ovf", int'(s_ovf), 1);
        drive(1, 1, 1, 1, 1, 0, 0, 0, 0);  tick();
        check("sat step0 q", int'(s_q), 9);
        check("sat step0 ovf", int'(s_ovf), 0);
        drive(1, 1, 1, 1, 1, 1, 0, 20, 0); tick();
        check("sat dn clamp q", int'(s_q), 0);
        check("sat dn clamp ovf", int'(s_ovf), 0);
        check("sat dn tc", int'(s_tc), 1);
        drive(1, 1, 1, 1, 1, 1, 0, 1, 0);  tick();
        check("sat bottom q", int'(s_q), 0);
        check("sat bottom ovf", int'(s_ovf), 1);
        tick();
        check("sat bottom again ovf", int'(s_ovf), 1);
        drive(1, 1, 1, 1, 1, 0, 0, 1, 0);  tick();
        check("sat leave bottom q", int'(s_q), 1);
        check("sat leave bottom ovf", int'(s_ovf), 0);

        // Randomized run against the model
        drive(0, 1, 1, 1, 1, 0, 0, 0, 0);
        tick();
        mw.q = 0; mw.ovf = 0; mw.lerr = 0;
        ms = mw; mf = mw;
        for (int n = 0; n < 3000; n++) begin
            rstb = ($urandom_range(0, 59) != 0);
            clrb = ($urandom_range(0, 29) != 0);
            ldb  = ($urandom_range(0, 9) != 0);
            hdb  = ($urandom_range(0, 11) != 0);
            en   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) upb = ~upb;
            d    = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 12))
                                               : 8'($urandom);
            step = ($urandom_range(0, 5) != 0) ? 8'($urandom_range(0, 11))
                                               : 8'($urandom);
            cmp  = 8'($urandom_range(0, 10));
            f_d    = 4'($urandom);
            f_step = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 5))
                                                 : 4'($urandom);
            f_cmp  = 4'($urandom);
            mw = ref_next(mw, 10, 0, rstb, clrb, ldb, hdb, en, upb,
                          int'(d), int'(step));
            ms = ref_next(ms, 10, 1, rstb, clrb, ldb, hdb, en, upb,
                          int'(d), int'(step));
            mf = ref_next(mf, 16, 0, rstb, clrb, ldb, hdb, en, upb,
                          int'(f_d), int'(f_step));
            tick();
            check("rnd w q", int'(w_q), mw.q);
            check("rnd w ovf", int'(w_ovf), int'(mw.ovf));
            check("rnd w ld_err", int'(w_le), int'(mw.lerr));
            check("rnd w tc", int'(w_tc),
                  int'(upb ? (mw.q == 0) : (mw.q == 9)));
            check("rnd w match", int'(w_mt), int'(mw.q == int'(cmp)));
            check("rnd s q", int'(s_q), ms.q);
            check("rnd s ovf", int'(s_ovf), int'(ms.ovf));
            check("rnd s ld_err", int'(s_le), int'(ms.lerr));
            check("rnd f q", int'(f_q), mf.q);
            check("rnd f ovf", int'(f_ovf), int'(mf.ovf));
            check("rnd f ld_err", int'(f_le), int'(mf.lerr));
            check("rnd f tc", int'(f_tc),
                  int'(upb ? (mf.q == 0) : (mf.q == 15)));
            check("rnd f match", int'(f_mt), int'(mf.q == int'(f_cmp)));
        end

        // Cascade: two decades count 0..99 and wrap
        c_rstb = 1'b0;
        tick();
        check("chain reset lo", int'(lo_q), 0);
        check("chain reset hi", int'(hi_q), 0);
        c_rstb = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            tick();
            check($sformatf("chain%0d lo", n), int'(lo_q), n % 10);
            check($sformatf("chain%0d hi", n), int'(hi_q), (n / 10) % 10);
            check($sformatf("chain%0d lo ovf", n), int'(lo_ovf),
                  int'(n % 10 == 0));
            check($sformatf("chain%0d hi ovf", n), int'(hi_ovf),
                  int'(n == 100));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
